// File: rtl/branch_cache_update_scheduler.sv
// Branch cache update/clear scheduler.
// Purpose: arbitrates two jump-resolution requesters (round-robin) into a small
// update FIFO. The FIFO drains one entry per cycle onto the cache JUMP port. A
// flush request walks every cache index with CLEAR strobes and locks search
// until the walk finishes.
// Ports:
//   iCLOCK, iRESET (async, active-high), iRESET_SYNC (sync, same effect)
//   iFLUSH_REQ                 start or restart the invalidation walk
//   oFLUSH_BUSY, oSEARCH_LOCK  high while the walk is in progress
//   iUPDn_REQ/HIT/ADDR/INST_ADDR, oUPDn_ACK (n = 0, 1)  update requesters
//   oJUMP_STB/HIT/ADDR/INST_ADDR  registered cache update port
//   oCLEAR_STB, oCLEAR_INDEX      cache invalidate port
module branch_cache_update_scheduler #(
  parameter int unsigned P_ENTRY_N    = 16,
  parameter int unsigned P_ENTRY_W    = 4,
  parameter int unsigned P_FIFO_DEPTH = 4,
  parameter int unsigned P_FIFO_W     = 2
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET,
  input  logic                 iRESET_SYNC,
  input  logic                 iFLUSH_REQ,
  output logic                 oFLUSH_BUSY,
  output logic                 oSEARCH_LOCK,
  input  logic                 iUPD0_REQ,
  input  logic                 iUPD0_HIT,
  input  logic [31:0]          iUPD0_ADDR,
  input  logic [31:0]          iUPD0_INST_ADDR,
  output logic                 oUPD0_ACK,
  input  logic                 iUPD1_REQ,
  input  logic                 iUPD1_HIT,
  input  logic [31:0]          iUPD1_ADDR,
  input  logic [31:0]          iUPD1_INST_ADDR,
  output logic                 oUPD1_ACK,
  output logic                 oJUMP_STB,
  output logic                 oJUMP_HIT,
  output logic [31:0]          oJUMP_ADDR,
  output logic [31:0]          oJUMP_INST_ADDR,
  output logic                 oCLEAR_STB,
  output logic [P_ENTRY_W-1:0] oCLEAR_INDEX
);

  localparam logic                 L_ST_RUN     = 1'b0;
  localparam logic                 L_ST_CLEAR   = 1'b1;
  localparam logic [P_ENTRY_W-1:0] L_LAST_INDEX = P_ENTRY_W'(P_ENTRY_N - 1);
  localparam logic [P_FIFO_W:0]    L_FULL_COUNT = (P_FIFO_W + 1)'(P_FIFO_DEPTH);

  logic                 r_state, w_state_d;
  logic [P_ENTRY_W-1:0] r_index, w_index_d;
  logic                 r_rr, w_rr_d;
  logic [P_FIFO_W-1:0]  r_wr_ptr, w_wr_ptr_d;
  logic [P_FIFO_W-1:0]  r_rd_ptr, w_rd_ptr_d;
  logic [P_FIFO_W:0]    r_count, w_count_d;
  logic                 r_jump_stb, w_jump_stb_d;
  logic                 r_jump_hit, w_jump_hit_d;
  logic [31:0]          r_jump_addr, w_jump_addr_d;
  logic [31:0]          r_jump_inst, w_jump_inst_d;

  logic                 r_fifo_hit  [P_FIFO_DEPTH];
  logic [31:0]          r_fifo_addr [P_FIFO_DEPTH];
  logic [31:0]          r_fifo_inst [P_FIFO_DEPTH];

  logic w_run, w_full, w_empty, w_arb_ok, w_ack0, w_ack1, w_push, w_pop;

  assign w_run    = (r_state == L_ST_RUN);
  assign w_full   = (r_count == L_FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign w_arb_ok = w_run && !w_full && !iFLUSH_REQ;
  // r_rr = 0 favours UPD0 on a tie, r_rr = 1 favours UPD1.
  assign w_ack0   = w_arb_ok && iUPD0_REQ && (!iUPD1_REQ || !r_rr);
  assign w_ack1   = w_arb_ok && iUPD1_REQ && (!iUPD0_REQ ||  r_rr);
  assign w_push   = w_ack0 || w_ack1;
  // A flush cycle discards the queue, so nothing is popped in it.
  assign w_pop    = w_run && !w_empty && !iFLUSH_REQ;

  always_comb begin
    w_state_d     = r_state;
    w_index_d     = r_index;
    w_rr_d        = r_rr;
    w_wr_ptr_d    = r_wr_ptr;
    w_rd_ptr_d    = r_rd_ptr;
    w_count_d     = r_count;
    w_jump_stb_d  = 1'b0;
    w_jump_hit_d  = r_jump_hit;
    w_jump_addr_d = r_jump_addr;
    w_jump_inst_d = r_jump_inst;
    if (iRESET_SYNC) begin
      w_state_d     = L_ST_RUN;
      w_index_d     = '0;
      w_rr_d        = 1'b0;
      w_wr_ptr_d    = '0;
      w_rd_ptr_d    = '0;
      w_count_d     = '0;
      w_jump_hit_d  = 1'b0;
      w_jump_addr_d = '0;
      w_jump_inst_d = '0;
    end else if (w_run) begin
      if (iFLUSH_REQ) begin
        w_state_d  = L_ST_CLEAR;
        w_index_d  = '0;
        w_wr_ptr_d = '0;
        w_rd_ptr_d = '0;
        w_count_d  = '0;
      end else begin
        if (w_push) begin
          w_wr_ptr_d = r_wr_ptr + P_FIFO_W'(1);
          w_rr_d     = w_ack0;
        end
        if (w_pop) begin
          w_rd_ptr_d    = r_rd_ptr + P_FIFO_W'(1);
          w_jump_stb_d  = 1'b1;
          w_jump_hit_d  = r_fifo_hit[r_rd_ptr];
          w_jump_addr_d = r_fifo_addr[r_rd_ptr];
          w_jump_inst_d = r_fifo_inst[r_rd_ptr];
        end
        unique case ({w_push, w_pop})
          2'b10:   w_count_d = r_count + (P_FIFO_W + 1)'(1);
          2'b01:   w_count_d = r_count - (P_FIFO_W + 1)'(1);
          default: w_count_d = r_count;
        endcase
      end
    end else begin
      if (iFLUSH_REQ) begin
        w_index_d = '0;
      end else if (r_index == L_LAST_INDEX) begin
        w_state_d = L_ST_RUN;
        w_index_d = '0;
      end else begin
        w_index_d = r_index + P_ENTRY_W'(1);
      end
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state     <= L_ST_RUN;
      r_index     <= '0;
      r_rr        <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_jump_stb  <= 1'b0;
      r_jump_hit  <= 1'b0;
      r_jump_addr <= '0;
      r_jump_inst <= '0;
    end else begin
      r_state     <= w_state_d;
      r_index     <= w_index_d;
      r_rr        <= w_rr_d;
      r_wr_ptr    <= w_wr_ptr_d;
      r_rd_ptr    <= w_rd_ptr_d;
      r_count     <= w_count_d;
      r_jump_stb  <= w_jump_stb_d;
      r_jump_hit  <= w_jump_hit_d;
      r_jump_addr <= w_jump_addr_d;
      r_jump_inst <= w_jump_inst_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_fifo_hit[r_wr_ptr]  <= w_ack1 ? iUPD1_HIT       : iUPD0_HIT;
      r_fifo_addr[r_wr_ptr] <= w_ack1 ? iUPD1_ADDR      : iUPD0_ADDR;
      r_fifo_inst[r_wr_ptr] <= w_ack1 ? iUPD1_INST_ADDR : iUPD0_INST_ADDR;
    end
  end

  assign oUPD0_ACK       = w_ack0;
  assign oUPD1_ACK       = w_ack1;
  assign oJUMP_STB       = r_jump_stb;
  assign oJUMP_HIT       = r_jump_hit;
  assign oJUMP_ADDR      = r_jump_addr;
  assign oJUMP_INST_ADDR = r_jump_inst;
  assign oCLEAR_STB      = (r_state == L_ST_CLEAR);
  assign oCLEAR_INDEX    = r_index;
  assign oFLUSH_BUSY     = (r_state == L_ST_CLEAR);
  assign oSEARCH_LOCK    = (r_state == L_ST_CLEAR);

endmodule

// File: tb/tb_branch_cache_update_scheduler.sv
module tb_branch_cache_update_scheduler;

  typedef struct {
    logic        hit;
    logic [31:0] addr;
    logic [31:0] inst;
  } upd_t;

  logic        clk = 1'b0;
  logic        rst, rst_sync, flush;
  logic        req0, hit0, req1, hit1;
  logic [31:0] addr0, inst0, addr1, inst1;
  logic        busy, lock, ack0, ack1, jstb, jhit, cstb;
  logic [31:0] jaddr, jinst;
  logic [3:0]  cidx;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  branch_cache_update_scheduler dut (
    .iCLOCK         (clk),
    .iRESET         (rst),
    .iRESET_SYNC    (rst_sync),
    .iFLUSH_REQ     (flush),
    .oFLUSH_BUSY    (busy),
    .oSEARCH_LOCK   (lock),
    .iUPD0_REQ      (req0),
    .iUPD0_HIT      (hit0),
    .iUPD0_ADDR     (addr0),
    .iUPD0_INST_ADDR(inst0),
    .oUPD0_ACK      (ack0),
    .iUPD1_REQ      (req1),
    .iUPD1_HIT      (hit1),
    .iUPD1_ADDR     (addr1),
    .iUPD1_INST_ADDR(inst1),
    .oUPD1_ACK      (ack1),
    .oJUMP_STB      (jstb),
    .oJUMP_HIT      (jhit),
    .oJUMP_ADDR     (jaddr),
    .oJUMP_INST_ADDR(jinst),
    .oCLEAR_STB     (cstb),
    .oCLEAR_INDEX   (cidx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_sync = 1'b0; flush = 1'b0;
    req0 = 1'b0; hit0 = 1'b0; addr0 = '0; inst0 = '0;
    req1 = 1'b0; hit1 = 1'b0; addr1 = '0; inst1 = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    req0 = 1'b1;
    #2;
    n_total++; if (jstb !== 1'b0) begin n_bad++; $display("FAIL reset_jstb got=%b want=0", jstb); end
    n_total++; if (cstb !== 1'b0) begin n_bad++; $display("FAIL reset_cstb got=%b want=0", cstb); end
    n_total++; if ({busy, lock} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_lock got=%b want=00", {busy, lock}); end
    n_total++; if (cidx !== 4'd0) begin n_bad++; $display("FAIL reset_index got=%0d want=0", cidx); end
    n_total++; if ({jhit, jaddr, jinst} !== 65'd0) begin n_bad++; $display("FAIL reset_jfields got=%h want=0", {jhit, jaddr, jinst}); end
    n_total++; if ({ack0, ack1} !== 2'b10) begin n_bad++; $display("FAIL reset_ack got=%b want=10", {ack0, ack1}); end
    step();
    rst = 1'b0;
    req0 = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; hit0 = 1'b1; addr0 = 32'h100; inst0 = 32'h40;
    #1;
    n_total++; if ({ack0, ack1} !== 2'b10) begin n_bad++; $display("FAIL single_ack got=%b want=10", {ack0, ack1}); end
    step();
    req0 = 1'b0;
    #1;
    n_total++; if (jstb !== 1'b0) begin n_bad++; $display("FAIL single_early_stb got=%b want=0", jstb); end
    step();
    n_total++; if (jstb !== 1'b1) begin n_bad++; $display("FAIL single_stb got=%b want=1", jstb); end
    n_total++; if ({jhit, jaddr, jinst} !== {1'b1, 32'h100, 32'h40}) begin
      n_bad++; $display("FAIL single_fields got=%b/%h/%h want=1/100/40", jhit, jaddr, jinst);
    end
    step();
    n_total++; if (jstb !== 1'b0) begin n_bad++; $display("FAIL single_stb_once got=%b want=0", jstb); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    do_reset();
    hit0 = 1'b1; addr0 = 32'hA00; inst0 = 32'hA0;
    hit1 = 1'b0; addr1 = 32'hB00; inst1 = 32'hB0;
    for (int k = 0; k < 6; k++) begin
      req0 = (k < 4);
      req1 = (k < 4);
      #1;
      if (k < 4) begin
        n_total++; if ({ack0, ack1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL rr_ack k=%0d got=%b", k, {ack0, ack1});
        end
      end
      if (k >= 2) begin
        exp_addr = ((k - 2) % 2 == 0) ? 32'hA00 : 32'hB00;
        n_total++; if ({jstb, jaddr} !== {1'b1, exp_addr}) begin
          n_bad++; $display("FAIL rr_jump k=%0d got=%b/%h want=1/%h", k, jstb, jaddr, exp_addr);
        end
      end else begin
        n_total++; if (jstb !== 1'b0) begin n_bad++; $display("FAIL rr_early_stb k=%0d got=%b want=0", k, jstb); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req0 = (k < 5); hit0 = k[0]; addr0 = 32'h3000 + 32'(k); inst0 = 32'h200 + 32'(4 * k);
      #1;
      if (k < 5) begin
        n_total++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL b2b_ack k=%0d got=%b want=1", k, ack0); end
      end
      if (jstb === 1'b1) begin
        seen++;
        n_total++; if ({jhit, jaddr, jinst} !== {k[0], 32'h3000 + 32'(k - 2), 32'h200 + 32'(4 * (k - 2))}) begin
          n_bad++; $display("FAIL b2b_fields k=%0d got=%b/%h/%h", k, jhit, jaddr, jinst);
        end
      end
      step();
    end
    n_total++; if (seen !== 5) begin n_bad++; $display("FAIL b2b_count got=%0d want=5", seen); end
  endtask

  task automatic test_flush();
    int n_clr = 0;
    do_reset();
    req0 = 1'b1; hit0 = 1'b1; addr0 = 32'h500; inst0 = 32'h50;
    #1;
    n_total++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL flush_ack_a got=%b want=1", ack0); end
    step();
    req0 = 1'b0; req1 = 1'b1; hit1 = 1'b1; addr1 = 32'h600; inst1 = 32'h60;
    #1;
    n_total++; if (ack1 !== 1'b1) begin n_bad++; $display("FAIL flush_ack_b got=%b want=1", ack1); end
    step();
    flush = 1'b1; req1 = 1'b0; req0 = 1'b1; addr0 = 32'h700; inst0 = 32'h70;
    #1;
    n_total++; if ({ack0, ack1} !== 2'b00) begin n_bad++; $display("FAIL flush_req_ack got=%b want=00", {ack0, ack1}); end
    n_total++; if ({jstb, jaddr} !== {1'b1, 32'h500}) begin n_bad++; $display("FAIL flush_last_jump got=%b/%h want=1/500", jstb, jaddr); end
    step();
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (cstb === 1'b1) n_clr++;
      n_total++; if ({cstb, busy, lock, cidx} !== {3'b111, 4'(i)}) begin
        n_bad++; $display("FAIL flush_walk i=%0d got=%b%b%b/%0d", i, cstb, busy, lock, cidx);
      end
      n_total++; if ({ack0, ack1, jstb} !== 3'b000) begin
        n_bad++; $display("FAIL flush_quiet i=%0d got=%b want=000", i, {ack0, ack1, jstb});
      end
      step();
    end
    #1;
    n_total++; if (n_clr !== 16) begin n_bad++; $display("FAIL flush_clr_count got=%0d want=16", n_clr); end
    n_total++; if ({cstb, busy, lock} !== 3'b000) begin n_bad++; $display("FAIL flush_end got=%b want=000", {cstb, busy, lock}); end
    n_total++; if (ack0 !== 1'b1) begin n_bad++; $display("FAIL flush_resume_ack got=%b want=1", ack0); end
    step();
    req0 = 1'b0;
    #1;
    n_total++; if (jstb !== 1'b0) begin n_bad++; $display("FAIL flush_discarded got=%b/%h want=0", jstb, jaddr); end
    step();
    n_total++; if ({jstb, jaddr} !== {1'b1, 32'h700}) begin n_bad++; $display("FAIL flush_resume_jump got=%b/%h want=1/700", jstb, jaddr); end
  endtask

  task automatic test_reflush();
    int n_clr = 0;
    int exp_idx;
    do_reset();
    flush = 1'b1;
    step();
    for (int k = 1; k <= 24; k++) begin
      flush = (k == 8);
      exp_idx = (k <= 8) ? k - 1 : k - 9;
      #1;
      if (cstb === 1'b1) n_clr++;
      n_total++; if ({cstb, cidx} !== {1'b1, 4'(exp_idx)}) begin
        n_bad++; $display("FAIL reflush_walk k=%0d got=%b/%0d want=1/%0d", k, cstb, cidx, exp_idx);
      end
      step();
    end
    flush = 1'b0;
    #1;
    n_total++; if ({cstb, busy} !== 2'b00) begin n_bad++; $display("FAIL reflush_end got=%b want=00", {cstb, busy}); end
    n_total++; if (n_clr !== 24) begin n_bad++; $display("FAIL reflush_total got=%0d want=24", n_clr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #1;
    n_total++; if (cidx !== 4'd5) begin n_bad++; $display("FAIL rmid_index got=%0d want=5", cidx); end
    rst = 1'b1;
    #1;
    n_total++; if ({cstb, busy, lock, cidx} !== 7'd0) begin
      n_bad++; $display("FAIL rmid_async got=%b%b%b/%0d want=0", cstb, busy, lock, cidx);
    end
    step();
    rst = 1'b0;
    req0 = 1'b1; addr0 = 32'h900;
    #1;
    n_total++; if ({cstb, ack0} !== 2'b01) begin n_bad++; $display("FAIL rmid_run got=%b want=01", {cstb, ack0}); end
    step();
    req0 = 1'b0;
    step();
    n_total++; if ({jstb, jaddr} !== {1'b1, 32'h900}) begin n_bad++; $display("FAIL rmid_jump got=%b/%h", jstb, jaddr); end
    rst = 1'b1;
    #1;
    n_total++; if ({jstb, jaddr} !== 33'd0) begin n_bad++; $display("FAIL rmid_drain_abort got=%b/%h want=0", jstb, jaddr); end
    step();
    rst = 1'b0;
    // Sync reset in the cycle a pop would register must suppress the strobe.
    req0 = 1'b1; addr0 = 32'h910;
    step();
    req0 = 1'b0; rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++; if (jstb !== 1'b0) begin n_bad++; $display("FAIL rsync_drain i=%0d got=%b want=0", i, jstb); end
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    #1;
    n_total++; if ({cstb, busy, cidx} !== 6'd0) begin n_bad++; $display("FAIL rsync_walk got=%b%b/%0d want=0", cstb, busy, cidx); end
  endtask

  task automatic test_random();
    upd_t q[$];
    upd_t mj, tmp;
    bit   mjv = 0, mclr = 0, mrr = 0, e0 = 0, e1 = 0, ok, a0_last = 0, a1_last = 0;
    int   midx = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      // Payloads change only when idle or after acceptance.
      if (!req0 || a0_last) begin
        req0 = ($urandom % 3) != 0; hit0 = 1'($urandom); addr0 = $urandom; inst0 = $urandom;
      end
      if (!req1 || a1_last) begin
        req1 = ($urandom % 3) != 0; hit1 = 1'($urandom); addr1 = $urandom; inst1 = $urandom;
      end
      flush = ($urandom % 60) == 0;
      #1;
      ok = !mclr && (q.size() < 4) && !flush;
      e0 = ok && req0 && (!req1 || !mrr);
      e1 = ok && req1 && (!req0 || mrr);
      n_total++; if ({ack0, ack1} !== {e0, e1}) begin
        n_bad++; $display("FAIL rand_ack c=%0d got=%b want=%b%b", c, {ack0, ack1}, e0, e1);
      end
      n_total++; if (jstb !== mjv) begin n_bad++; $display("FAIL rand_jstb c=%0d got=%b want=%b", c, jstb, mjv); end
      if (mjv) begin
        n_total++; if ({jhit, jaddr, jinst} !== {mj.hit, mj.addr, mj.inst}) begin
          n_bad++; $display("FAIL rand_fields c=%0d got=%b/%h/%h want=%b/%h/%h", c, jhit, jaddr, jinst,
                            mj.hit, mj.addr, mj.inst);
        end
      end
      n_total++; if ({cstb, busy, lock, cidx} !== {mclr, mclr, mclr, 4'(midx)}) begin
        n_bad++; $display("FAIL rand_clear c=%0d got=%b%b%b/%0d want=%b/%0d", c, cstb, busy, lock, cidx, mclr, midx);
      end
      if (!mclr) begin
        if (flush) begin
          mclr = 1; midx = 0; q.delete(); mjv = 0;
        end else begin
          mjv = q.size() > 0;
          if (mjv) mj = q.pop_front();
          if (e0) begin tmp.hit = hit0; tmp.addr = addr0; tmp.inst = inst0; q.push_back(tmp); mrr = 1; end
          if (e1) begin tmp.hit = hit1; tmp.addr = addr1; tmp.inst = inst1; q.push_back(tmp); mrr = 0; end
        end
      end else begin
        mjv = 0;
        if (flush) midx = 0;
        else if (midx == 15) begin mclr = 0; midx = 0; end
        else midx++;
      end
      a0_last = e0;
      a1_last = e1;
      step();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_flush();
    test_reflush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
